// File: rtl/branch_pkg.sv
// Shared branch-unit definitions: funct3 condition codes, BHT counter encodings and
// the saturating counter update.
package branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_cnt_e;

   localparam bht_cnt_e BHT_RST = WNT;

   function automatic bht_cnt_e bht_next(input bht_cnt_e cnt, input logic taken);
      logic [1:0] val;
      val = cnt;
      if (taken) begin
         if (cnt != ST) val = val + 2'd1;
      end else begin
         if (cnt != SNT) val = val - 2'd1;
      end
      return bht_cnt_e'(val);
   endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, combinational read for fetch,
// one synchronous update port for resolved branches (no read/write bypass).
module branch_bht
   import branch_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_pred_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   bht_cnt_e   cnt_q [DEPTH];
   bht_cnt_e   wr_cnt_d;
   logic [1:0] rd_cnt;

   assign rd_cnt    = cnt_q[rd_idx_i];
   assign rd_pred_o = rd_cnt[1];
   assign wr_cnt_d  = bht_next(cnt_q[wr_idx_i], wr_taken_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= BHT_RST;
      end else if (wr_en_i) begin
         cnt_q[wr_idx_i] <= wr_cnt_d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: direct rs1/rs2 compare, registered outcome/target/mispredict,
// BHT training. Optional statistics counters enabled by BRANCH_STATS_EN.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            pred_taken,
   input  logic            in_valid,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_pred,
   output logic            res_valid,
   output logic            res_taken,
   output logic [XLEN-1:0] res_target,
   output logic            res_mispred,
   output logic            res_illegal
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispreds
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic            res_valid_q, res_taken_q, res_mispred_q, res_illegal_q;
   logic [XLEN-1:0] res_target_q;
   logic            taken_d, illegal_d, mispred_d, accept;
   logic [XLEN-1:0] target_d;
   logic            fetch_pc_unused;

   // A redirect in flight means the branch now in EX is on the wrong path.
   assign accept = in_valid && !(res_valid_q && res_mispred_q);

   always_comb begin
      taken_d   = 1'b0;
      illegal_d = 1'b0;
      case (in_funct3)
         F3_BEQ:  taken_d = (in_rs1 == in_rs2);
         F3_BNE:  taken_d = (in_rs1 != in_rs2);
         F3_BLT:  taken_d = ($signed(in_rs1) <  $signed(in_rs2));
         F3_BGE:  taken_d = ($signed(in_rs1) >= $signed(in_rs2));
         F3_BLTU: taken_d = (in_rs1 <  in_rs2);
         F3_BGEU: taken_d = (in_rs1 >= in_rs2);
         default: illegal_d = 1'b1;
      endcase
   end

   assign target_d  = in_pc + (taken_d ? in_imm : XLEN'(4));
   assign mispred_d = !illegal_d && (taken_d != in_pred);

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_q   <= 1'b0;
         res_taken_q   <= 1'b0;
         res_mispred_q <= 1'b0;
         res_illegal_q <= 1'b0;
         res_target_q  <= '0;
      end else begin
         res_valid_q <= accept;
         if (accept) begin
            res_taken_q   <= taken_d;
            res_mispred_q <= mispred_d;
            res_illegal_q <= illegal_d;
            res_target_q  <= target_d;
         end
      end
   end

   assign res_valid   = res_valid_q;
   assign res_taken   = res_taken_q;
   assign res_mispred = res_mispred_q;
   assign res_illegal = res_illegal_q;
   assign res_target  = res_target_q;

   assign fetch_pc_unused = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                              in_pc[XLEN-1:IDX_W+2], in_pc[1:0]};

   branch_bht #(
      .DEPTH (BHT_DEPTH),
      .IDX_W (IDX_W)
   ) u_bht (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (fetch_pc[IDX_W+1:2]),
      .rd_pred_o  (pred_taken),
      .wr_en_i    (accept && !illegal_d),
      .wr_idx_i   (in_pc[IDX_W+1:2]),
      .wr_taken_i (taken_d)
   );

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches_q, stat_mispreds_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q <= '0;
         stat_mispreds_q <= '0;
      end else if (accept && !illegal_d) begin
         stat_branches_q <= stat_branches_q + 32'd1;
         if (mispred_d) stat_mispreds_q <= stat_mispreds_q + 32'd1;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispreds = stat_mispreds_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases with literal expectations
// plus randomized traffic against a behavioural model. Honours BRANCH_STATS_EN.
module tb_branch_resolve_unit;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] fetch_pc = '0;
   logic        pred_taken;
   logic        in_valid = 1'b0;
   logic [2:0]  in_funct3 = '0;
   logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
   logic        in_pred = 1'b0;
   logic        res_valid, res_taken, res_mispred, res_illegal;
   logic [31:0] res_target;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_mispreds;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
      .in_valid(in_valid), .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_pc(in_pc), .in_imm(in_imm), .in_pred(in_pred),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .res_mispred(res_mispred), .res_illegal(res_illegal)
`ifdef BRANCH_STATS_EN
      , .stat_branches(stat_branches), .stat_mispreds(stat_mispreds)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          mb [DEPTH];
   bit          m_vld, m_tkn, m_mis, m_ill, m_started = 1'b0;
   logic [31:0] m_tgt, m_nbr, m_nmis;

   function automatic bit outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output bit ill);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ill = 1'b0;
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return a < b;
         3'd7: return a >= b;
         default: begin ill = 1'b1; return 1'b0; end
      endcase
   endfunction

   always @(posedge clk) begin : model
      bit acc, tk, il;
      int ix;
      if (rst) begin
         m_started = 1'b1;
         m_vld = 0; m_tkn = 0; m_mis = 0; m_ill = 0; m_tgt = '0;
         m_nbr = '0; m_nmis = '0;
         for (int i = 0; i < DEPTH; i++) mb[i] = 1;
      end else if (m_started) begin
         acc = in_valid && !(m_vld && m_mis);
         m_vld = acc;
         if (acc) begin
            tk = outcome(in_funct3, in_rs1, in_rs2, il);
            m_tkn = tk;
            m_ill = il;
            m_mis = !il && (tk != in_pred);
            m_tgt = in_pc + (tk ? in_imm : 32'd4);
            if (!il) begin
               ix = int'(in_pc[5:2]);
               mb[ix] = tk ? ((mb[ix] == 3) ? 3 : mb[ix] + 1) : ((mb[ix] == 0) ? 0 : mb[ix] - 1);
               m_nbr = m_nbr + 32'd1;
               if (m_mis) m_nmis = m_nmis + 32'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("res_valid", 32'(res_valid), 32'(m_vld));
         if (m_vld) begin
            chk("res_taken", 32'(res_taken), 32'(m_tkn));
            chk("res_mispred", 32'(res_mispred), 32'(m_mis));
            chk("res_illegal", 32'(res_illegal), 32'(m_ill));
            chk("res_target", res_target, m_tgt);
         end
         chk("pred_taken", 32'(pred_taken), 32'(mb[int'(fetch_pc[5:2])] >= 2));
`ifdef BRANCH_STATS_EN
         chk("stat_branches", stat_branches, m_nbr);
         chk("stat_mispreds", stat_mispreds, m_nmis);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
      @(posedge clk); #2;
      in_valid = 1'b1; in_funct3 = f; in_rs1 = a; in_rs2 = b;
      in_pc = pc; in_imm = imm; in_pred = pred;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   logic [31:0] vals [6];

   initial begin
      vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF_FFFF;
      vals[3] = 32'h7FFF_FFFF; vals[4] = 32'h8000_0000; vals[5] = 32'h5;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_res_valid", 32'(res_valid), 32'd0);
      chk("reset_pred", 32'(pred_taken), 32'd0);

      // BNE equal / unequal
      issue(3'b001, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0);
      chk("bne_eq_valid", 32'(res_valid), 32'd1);
      chk("bne_eq_taken", 32'(res_taken), 32'd0);
      chk("bne_eq_mis", 32'(res_mispred), 32'd0);
      chk("bne_eq_tgt", res_target, 32'h204);
      issue(3'b001, 32'd5, 32'd6, 32'h200, 32'h40, 1'b0);
      chk("bne_ne_taken", 32'(res_taken), 32'd1);
      chk("bne_ne_mis", 32'(res_mispred), 32'd1);
      chk("bne_ne_tgt", res_target, 32'h240);

      // signed vs unsigned compare
      issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'hFFFF_FFF0, 1'b1);
      chk("blt_taken", 32'(res_taken), 32'd1);
      chk("blt_tgt", res_target, 32'h1F8);
      issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'h10, 1'b1);
      chk("bltu_taken", 32'(res_taken), 32'd0);
      chk("bltu_mis", 32'(res_mispred), 32'd1);
      issue(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'h10, 1'b0);
      chk("bge_taken", 32'(res_taken), 32'd0);
      issue(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h208, 32'h10, 1'b0);
      chk("bgeu_taken", 32'(res_taken), 32'd1);
      chk("bgeu_tgt", res_target, 32'h218);

      // BHT training at pc 0x100
      do_reset();
      fetch_pc = 32'h100;
      #1 chk("train_pred0", 32'(pred_taken), 32'd0);
      issue(3'b000, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0);
      chk("train_pred1", 32'(pred_taken), 32'd1);
      issue(3'b000, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0);
      issue(3'b000, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0);
      chk("train_pred_st", 32'(pred_taken), 32'd1);
      issue(3'b001, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0);
      chk("train_nt1", 32'(pred_taken), 32'd1);
      issue(3'b001, 32'd7, 32'd7, 32'h100, 32'h20, 1'b0);
      chk("train_nt2", 32'(pred_taken), 32'd0);

      // wrong-path drop
      @(posedge clk); #2;
      in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd1; in_rs2 = 32'd2;
      in_pc = 32'h304; in_imm = 32'h80; in_pred = 1'b1;
      @(posedge clk); #1;
      chk("drop_a_mis", 32'(res_mispred), 32'd1);
      chk("drop_a_tgt", res_target, 32'h308);
      in_rs1 = 32'd3; in_rs2 = 32'd3; in_pc = 32'h348; in_pred = 1'b0;
      @(posedge clk); #1;
      chk("drop_b_valid", 32'(res_valid), 32'd0);
      in_pred = 1'b1; fetch_pc = 32'h348;
      #1 chk("drop_b_bht", 32'(pred_taken), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("drop_c_valid", 32'(res_valid), 32'd1);
      chk("drop_c_tgt", res_target, 32'h3C8);
      chk("drop_c_mis", 32'(res_mispred), 32'd0);
      chk("drop_c_pred", 32'(pred_taken), 32'd1);

      // illegal funct3
      issue(3'b010, 32'd3, 32'd3, 32'h348, 32'h80, 1'b1);
      chk("ill_flag", 32'(res_illegal), 32'd1);
      chk("ill_taken", 32'(res_taken), 32'd0);
      chk("ill_mis", 32'(res_mispred), 32'd0);
      chk("ill_bht", 32'(pred_taken), 32'd1);
`ifdef BRANCH_STATS_EN
      chk("ill_stat_br", stat_branches, 32'd7);
      chk("ill_stat_mis", stat_mispreds, 32'd4);
`endif

      // reset with a branch in flight
      @(posedge clk); #2;
      in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'd9; in_rs2 = 32'd9;
      in_pc = 32'h348; in_pred = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_valid", 32'(res_valid), 32'd0);
`ifdef BRANCH_STATS_EN
      chk("rst_stat", stat_branches, 32'd0);
`endif
      for (int i = 0; i < DEPTH; i++) begin
         fetch_pc = 32'(i * 4);
         #1 chk("rst_bht", 32'(pred_taken), 32'd0);
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         rst       = ($urandom_range(0, 299) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_funct3 = 3'($urandom);
         in_rs1    = ($urandom_range(0, 1) != 0) ? vals[$urandom_range(0, 5)] : $urandom;
         in_rs2    = ($urandom_range(0, 3) == 0) ? in_rs1 :
                     (($urandom_range(0, 1) != 0) ? vals[$urandom_range(0, 5)] : $urandom);
         in_pc     = ($urandom_range(0, 7) == 0) ? {$urandom, 2'b00} >> 2 << 2
                                                 : 32'h1000 + 32'($urandom_range(0, 40)) * 4;
         in_imm    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($signed(12'($urandom)) * 2);
         in_pred   = 1'($urandom);
         fetch_pc  = ($urandom_range(0, 1) != 0) ? in_pc : 32'h1000 + 32'($urandom_range(0, 40)) * 4;
      end
      @(posedge clk); #2;
      in_valid = 1'b0; rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
